// File: rtl/fifo_rd_framer_if.sv
// Bundles the FIFO read port and the framed output stream of the read-side unloader.
// The master modport is the framer; the slave modport is the FIFO plus downstream sink.
interface fifo_rd_framer_if #(
    parameter int DW = 64
);
    logic          fifo_rdempty;
    logic          fifo_rden;
    logic [DW:0]   fifo_dataout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  fifo_rdempty,
        input  fifo_dataout,
        input  m_ready,
        output fifo_rden,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_rdempty,
        output fifo_dataout,
        output m_ready,
        input  fifo_rden,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_rd_framer.sv
// Read-side unloader for the MAC FIFO: credit-limited reads into a 3-entry output buffer,
// EOP framing from the word MSB, truncation of overlong packets and packet/drop statistics.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for the first word of a packet
// ST_XFER  | inside a packet, words pushed and counted
// ST_FLUSH | packet was truncated, remaining words dropped up to EOP
module fifo_rd_framer #(
    parameter int DW        = 64,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    fifo_rd_framer_if.master bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_ovl
);

    localparam int              WC_W   = $clog2(MAX_WORDS + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic             rd_pend_q, rd_pend_d;
    logic [1:0]       occ_q, occ_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]    buf_data_q [3];
    logic [DW-1:0]    buf_data_d [3];
    logic [2:0]       buf_last_q, buf_last_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             err_ovl_q, err_ovl_d;

    logic             rden;
    logic             push;
    logic             push_last;
    logic             pop;
    logic             rd_eop;
    logic [DW-1:0]    rd_word;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts the buffer plus the word still in flight, so m_ready never reaches rden.
    assign rden    = !reset && !bus.fifo_rdempty &&
                     (({1'b0, occ_q} + {2'b00, rd_pend_q}) < 3'd3);
    assign rd_eop  = bus.fifo_dataout[DW];
    assign rd_word = bus.fifo_dataout[DW-1:0];
    assign pop     = (occ_q != 2'd0) && bus.m_ready;
    assign cnt_inc = cnt_q + WC_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_last  = 1'b0;
        err_ovl_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        rd_pend_d  = rden;
        if (rd_pend_q) begin
            case (state_q)
                ST_IDLE: begin
                    push      = 1'b1;
                    push_last = rd_eop;
                    if (!rd_eop) begin
                        state_d = ST_XFER;
                        cnt_d   = WC_W'(1);
                    end
                end
                ST_XFER: begin
                    push = 1'b1;
                    if (rd_eop) begin
                        push_last = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else if (cnt_inc == WC_MAX) begin
                        push_last = 1'b1;
                        err_ovl_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_FLUSH: begin
                    if (drop_cnt_q != {CNT_W{1'b1}}) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
                    if (rd_eop) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (push) begin
            buf_data_d[wr_ptr_q] = rd_word;
            buf_last_d[wr_ptr_q] = push_last;
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            if (buf_last_q[rd_ptr_q]) begin
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            buf_data_q <= '{default: '0};
            buf_last_q <= 3'b000;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_ovl_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_ovl_q  <= err_ovl_d;
        end
    end

    assign bus.fifo_rden = rden;
    assign bus.m_valid   = (occ_q != 2'd0);
    assign bus.m_data    = buf_data_q[rd_ptr_q];
    assign bus.m_last    = buf_last_q[rd_ptr_q];
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign err_ovl       = err_ovl_q;

endmodule
